// File: rtl/video_mnist_color_blend.sv
// Per-pixel colouring of MNIST classifier results: pass, binary, palette overlay or alpha blend.
// Two-stage pipeline; shadow config is copied to the active set on an accepted start-of-frame beat.
module video_mnist_color_blend #(
    parameter int         NUM_CLASS     = 10,
    parameter int         COMPONENTS    = 4,
    parameter int         DATA_WIDTH    = 8,
    parameter int         TDATA_WIDTH   = COMPONENTS * DATA_WIDTH,
    parameter int         TUSER_WIDTH   = 1,
    parameter int         TNUMBER_WIDTH = 4,
    parameter int         TCOUNT_WIDTH  = 4,
    parameter int         ALPHA_WIDTH   = 8,
    parameter logic [1:0] INIT_MODE     = 2'b10,
    parameter int         INIT_TH       = 5,
    parameter int         INIT_ALPHA    = 128
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     cfg_we,
    input  logic [7:0]               cfg_addr,
    input  logic [31:0]              cfg_wdata,
    output logic [31:0]              cfg_rdata,
    input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
    input  logic                     s_axi4s_tlast,
    input  logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber,
    input  logic [TCOUNT_WIDTH-1:0]  s_axi4s_tcount,
    input  logic [TDATA_WIDTH-1:0]   s_axi4s_tdata,
    input  logic                     s_axi4s_tbinary,
    input  logic                     s_axi4s_tvalid,
    output logic                     s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
    output logic                     m_axi4s_tlast,
    output logic [TDATA_WIDTH-1:0]   m_axi4s_tdata,
    output logic                     m_axi4s_tvalid,
    input  logic                     m_axi4s_tready
);

    localparam int MUL_W = DATA_WIDTH + ALPHA_WIDTH + 1;

    logic [1:0]               sh_mode, ac_mode, eff_mode;
    logic [TCOUNT_WIDTH-1:0]  sh_th, ac_th, eff_th;
    logic [ALPHA_WIDTH-1:0]   sh_alpha, ac_alpha, eff_alpha;
    logic                     sh_upd;
    logic [TDATA_WIDTH-1:0]   sh_pal [NUM_CLASS];
    logic [TDATA_WIDTH-1:0]   ac_pal [NUM_CLASS];
    logic [TDATA_WIDTH-1:0]   pal_pick;

    logic enable, accept, sof_load, hit;

    assign enable         = !m_axi4s_tvalid || m_axi4s_tready;
    assign s_axi4s_tready = enable;
    assign accept         = s_axi4s_tvalid && enable;
    assign sof_load       = accept && s_axi4s_tuser[0] && sh_upd;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sh_mode  <= INIT_MODE;
            sh_th    <= TCOUNT_WIDTH'(INIT_TH);
            sh_alpha <= ALPHA_WIDTH'(INIT_ALPHA);
            sh_upd   <= 1'b1;
            for (int i = 0; i < NUM_CLASS; i++) sh_pal[i] <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                8'h00: sh_mode  <= cfg_wdata[1:0];
                8'h01: sh_th    <= cfg_wdata[TCOUNT_WIDTH-1:0];
                8'h02: sh_alpha <= cfg_wdata[ALPHA_WIDTH-1:0];
                8'h03: sh_upd   <= cfg_wdata[0];
                default: begin
                    for (int i = 0; i < NUM_CLASS; i++)
                        if (cfg_addr == 8'(16 + i)) sh_pal[i] <= cfg_wdata[TDATA_WIDTH-1:0];
                end
            endcase
        end
    end

    // Shadow is sampled before this edge's write, so a same-cycle cfg_we is not seen here.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ac_mode  <= INIT_MODE;
            ac_th    <= TCOUNT_WIDTH'(INIT_TH);
            ac_alpha <= ALPHA_WIDTH'(INIT_ALPHA);
            for (int i = 0; i < NUM_CLASS; i++) ac_pal[i] <= '0;
        end else if (sof_load) begin
            ac_mode  <= sh_mode;
            ac_th    <= sh_th;
            ac_alpha <= sh_alpha;
            for (int i = 0; i < NUM_CLASS; i++) ac_pal[i] <= sh_pal[i];
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            8'h00: cfg_rdata[1:0]              = sh_mode;
            8'h01: cfg_rdata[TCOUNT_WIDTH-1:0] = sh_th;
            8'h02: cfg_rdata[ALPHA_WIDTH-1:0]  = sh_alpha;
            8'h03: cfg_rdata[0]                = sh_upd;
            default: begin
                for (int i = 0; i < NUM_CLASS; i++)
                    if (cfg_addr == 8'(16 + i)) cfg_rdata[TDATA_WIDTH-1:0] = sh_pal[i];
            end
        endcase
    end

    // The SOF beat itself is evaluated with the freshly loaded values.
    always_comb begin
        eff_mode  = sof_load ? sh_mode  : ac_mode;
        eff_th    = sof_load ? sh_th    : ac_th;
        eff_alpha = sof_load ? sh_alpha : ac_alpha;
        pal_pick  = '0;
        for (int i = 0; i < NUM_CLASS; i++)
            if (i == int'(s_axi4s_tnumber)) pal_pick = sof_load ? sh_pal[i] : ac_pal[i];
    end

    assign hit = (s_axi4s_tcount >= eff_th) && (int'(s_axi4s_tnumber) < NUM_CLASS);

    logic                   s1_valid, s1_last, s1_hit, s1_bin;
    logic [TUSER_WIDTH-1:0] s1_user;
    logic [TDATA_WIDTH-1:0] s1_src, s1_pal;
    logic [1:0]             s1_mode;
    logic [ALPHA_WIDTH-1:0] s1_alpha;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s1_valid <= 1'b0;
            s1_user  <= '0;
            s1_last  <= 1'b0;
            s1_src   <= '0;
            s1_pal   <= '0;
            s1_mode  <= '0;
            s1_alpha <= '0;
            s1_hit   <= 1'b0;
            s1_bin   <= 1'b0;
        end else if (enable) begin
            s1_valid <= s_axi4s_tvalid;
            s1_user  <= s_axi4s_tuser;
            s1_last  <= s_axi4s_tlast;
            s1_src   <= s_axi4s_tdata;
            s1_pal   <= pal_pick;
            s1_mode  <= eff_mode;
            s1_alpha <= eff_alpha;
            s1_hit   <= hit;
            s1_bin   <= s_axi4s_tbinary;
        end
    end

    logic [ALPHA_WIDTH:0]   inv_alpha;
    logic [MUL_W-1:0]       acc;
    logic [TDATA_WIDTH-1:0] out_pix;

    assign inv_alpha = (ALPHA_WIDTH+1)'(1 << ALPHA_WIDTH) - (ALPHA_WIDTH+1)'(s1_alpha);

    always_comb begin
        out_pix = s1_src;
        acc     = '0;
        case (s1_mode)
            2'd1: out_pix = {TDATA_WIDTH{s1_bin}};
            2'd2: if (s1_hit) out_pix = s1_pal;
            2'd3: begin
                if (s1_hit) begin
                    for (int c = 0; c < COMPONENTS; c++) begin
                        acc = MUL_W'(s1_src[c*DATA_WIDTH +: DATA_WIDTH]) * MUL_W'(inv_alpha)
                            + MUL_W'(s1_pal[c*DATA_WIDTH +: DATA_WIDTH]) * MUL_W'(s1_alpha);
                        out_pix[c*DATA_WIDTH +: DATA_WIDTH] = acc[ALPHA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axi4s_tvalid <= 1'b0;
            m_axi4s_tdata  <= '0;
            m_axi4s_tuser  <= '0;
            m_axi4s_tlast  <= 1'b0;
        end else if (enable) begin
            m_axi4s_tvalid <= s1_valid;
            m_axi4s_tdata  <= out_pix;
            m_axi4s_tuser  <= s1_user;
            m_axi4s_tlast  <= s1_last;
        end
    end

endmodule

// File: tb/tb_video_mnist_color_blend.sv
// Bench for video_mnist_color_blend: vector table, config-timing sequences and a
// randomized backpressured stream checked against a spec-level scoreboard.
module tb_video_mnist_color_blend;

    logic        aclk = 1'b0;
    logic        areset;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_wdata, cfg_rdata;
    logic [0:0]  s_tuser, m_tuser;
    logic        s_tlast, m_tlast;
    logic [3:0]  s_tnumber, s_tcount;
    logic [31:0] s_tdata, m_tdata;
    logic        s_tbinary, s_tvalid, s_tready, m_tvalid, m_tready;

    always #5 aclk = ~aclk;

    video_mnist_color_blend dut (
        .aclk(aclk), .areset(areset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tnumber(s_tnumber),
        .s_axi4s_tcount(s_tcount), .s_axi4s_tdata(s_tdata), .s_axi4s_tbinary(s_tbinary),
        .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready),
        .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tdata(m_tdata),
        .m_axi4s_tvalid(m_tvalid), .m_axi4s_tready(m_tready)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          mode;
        int          th;
        int          alpha;
        int          pidx;
        logic [31:0] pval;
        int          num;
        int          cnt;
        logic [31:0] data;
        bit          bin;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [12];

    typedef struct {
        logic [31:0] d;
        bit          u;
        bit          l;
    } beat_t;
    beat_t q [$];

    int          sh_mode, sh_th, sh_alpha, ac_mode, ac_th, ac_alpha;
    bit          sh_upd;
    logic [31:0] sh_pal [10];
    logic [31:0] ac_pal [10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [31:0] ref_pix(input int mode, input int th, input int alpha,
                                            input logic [31:0] pal, input int num, input int cnt,
                                            input logic [31:0] src, input bit bin);
        logic [31:0] r;
        bit hit;
        hit = (cnt >= th) && (num < 10);
        r = src;
        if (mode == 1) r = bin ? 32'hFFFF_FFFF : 32'h0;
        else if (mode == 2 && hit) r = pal;
        else if (mode == 3 && hit)
            for (int c = 0; c < 4; c++)
                r[c*8 +: 8] = 8'((int'(src[c*8 +: 8]) * (256 - alpha) + int'(pal[c*8 +: 8]) * alpha) / 256);
        return r;
    endfunction

    function automatic void model_reset();
        sh_mode = 2; sh_th = 5; sh_alpha = 128; sh_upd = 1'b1;
        ac_mode = 2; ac_th = 5; ac_alpha = 128;
        for (int i = 0; i < 10; i++) begin
            sh_pal[i] = '0;
            ac_pal[i] = '0;
        end
    endfunction

    // Scoreboard: observes handshakes at the falling edge, i.e. what the next rising edge commits.
    task automatic monitor();
        bit          hold = 1'b0;
        logic [31:0] hd;
        logic        hu, hl;
        beat_t       b, e;
        forever begin
            @(negedge aclk);
            if (areset) begin
                q.delete();
                model_reset();
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("stall_valid", {31'b0, m_tvalid}, 32'h1);
                    chk("stall_data", m_tdata, hd);
                    chk("stall_ul", {30'b0, m_tuser[0], m_tlast}, {30'b0, hu, hl});
                end
                hold = m_tvalid && !m_tready;
                hd = m_tdata; hu = m_tuser[0]; hl = m_tlast;
                if (m_tvalid && m_tready) begin
                    if (q.size() == 0) begin
                        chk("sb_extra_beat", m_tdata, 32'hx);
                    end else begin
                        e = q.pop_front();
                        chk("sb_data", m_tdata, e.d);
                        chk("sb_user_last", {30'b0, m_tuser[0], m_tlast}, {30'b0, e.u, e.l});
                    end
                end
                if (s_tvalid && s_tready) begin
                    if (s_tuser[0] && sh_upd) begin
                        ac_mode = sh_mode; ac_th = sh_th; ac_alpha = sh_alpha;
                        for (int i = 0; i < 10; i++) ac_pal[i] = sh_pal[i];
                    end
                    b.d = ref_pix(ac_mode, ac_th, ac_alpha,
                                  (s_tnumber < 10) ? ac_pal[s_tnumber] : 32'h0,
                                  int'(s_tnumber), int'(s_tcount), s_tdata, s_tbinary);
                    b.u = s_tuser[0];
                    b.l = s_tlast;
                    q.push_back(b);
                end
                if (cfg_we) begin
                    case (cfg_addr)
                        8'h00: sh_mode  = int'(cfg_wdata[1:0]);
                        8'h01: sh_th    = int'(cfg_wdata[3:0]);
                        8'h02: sh_alpha = int'(cfg_wdata[7:0]);
                        8'h03: sh_upd   = cfg_wdata[0];
                        default: if (cfg_addr >= 8'h10 && cfg_addr < 8'h1A) sh_pal[cfg_addr - 8'h10] = cfg_wdata;
                    endcase
                end
            end
        end
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge aclk); #1;
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge aclk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] want);
        cfg_addr = a;
        #1;
        chk(name, cfg_rdata, want);
    endtask

    task automatic send_beat(input bit u, input bit l, input int num, input int cnt,
                             input logic [31:0] d, input bit bin,
                             input bit we, input logic [7:0] wa, input logic [31:0] wd);
        bit ok = 1'b0;
        @(posedge aclk); #1;
        s_tuser = u; s_tlast = l; s_tnumber = 4'(num); s_tcount = 4'(cnt);
        s_tdata = d; s_tbinary = bin; s_tvalid = 1'b1;
        cfg_we = we; cfg_addr = wa; cfg_wdata = wd;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge aclk);
            if (s_tready) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 32'h0, 32'h1);
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic send_check(input string name, input bit u, input bit l, input int num,
                              input int cnt, input logic [31:0] d, input bit bin,
                              input logic [31:0] exp,
                              input bit we = 1'b0, input logic [7:0] wa = 8'h0,
                              input logic [31:0] wd = 32'h0);
        int n = 0;
        send_beat(u, l, num, cnt, d, bin, we, wa, wd);
        for (int i = 1; i <= 20 && n == 0; i++) begin
            @(negedge aclk);
            if (m_tvalid) n = i;
        end
        chk({name, "_latency"}, 32'(n), 32'd2);
        chk(name, m_tdata, exp);
    endtask

    task automatic run_stream(input int nbeats, input int rst_at);
        int sent = 0;
        bit acc;
        int r;
        s_tvalid = 1'b0;
        for (int cyc = 0; cyc < 3000 && sent < nbeats; cyc++) begin
            @(negedge aclk);
            acc = s_tvalid && s_tready;
            @(posedge aclk); #1;
            if (acc) sent++;
            if (rst_at >= 0 && sent >= rst_at) begin
                areset = 1'b1;
                s_tvalid = 1'b0;
                cfg_we = 1'b0;
                #1;
                chk("rst_tvalid", {31'b0, m_tvalid}, 32'h0);
                chk("rst_tdata", m_tdata, 32'h0);
                rd_chk("rst_mode", 8'h00, 32'h2);
                rd_chk("rst_th", 8'h01, 32'h5);
                rd_chk("rst_alpha", 8'h02, 32'd128);
                rd_chk("rst_upd", 8'h03, 32'h1);
                rd_chk("rst_pal3", 8'h13, 32'h0);
                @(negedge aclk);
                @(posedge aclk); #1;
                areset = 1'b0;
                m_tready = 1'b1;
                return;
            end
            cfg_we = ($urandom_range(0, 7) == 0);
            if (cfg_we) begin
                r = $urandom_range(0, 5);
                cfg_addr  = (r < 3) ? 8'(r) : 8'(16 + $urandom_range(0, 9));
                cfg_wdata = $urandom;
            end
            if (!s_tvalid || acc) begin
                if (sent < nbeats && $urandom_range(0, 3) != 0) begin
                    s_tvalid  = 1'b1;
                    s_tuser   = (sent % 16 == 0);
                    s_tlast   = (sent % 16 == 15);
                    s_tnumber = 4'($urandom_range(0, 15));
                    s_tcount  = 4'($urandom_range(0, 15));
                    s_tdata   = $urandom;
                    s_tbinary = 1'($urandom_range(0, 1));
                end else begin
                    s_tvalid = 1'b0;
                end
            end
            m_tready = 1'($urandom_range(0, 1));
        end
        cfg_we = 1'b0;
        s_tvalid = 1'b0;
        chk("stream_sent", 32'(sent), 32'(nbeats));
        m_tready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge aclk);
        chk("stream_drained", 32'(q.size()), 32'h0);
    endtask

    initial begin
        vecs[0]  = '{2, 5, 128, 3, 32'h00FF0000, 3,  5,  32'h11223344, 1'b0, 32'h00FF0000};
        vecs[1]  = '{2, 5, 128, 3, 32'h00FF0000, 3,  4,  32'h11223344, 1'b0, 32'h11223344};
        vecs[2]  = '{3, 5, 128, 7, 32'hFF000000, 7,  5,  32'h00808080, 1'b0, 32'h7F404040};
        vecs[3]  = '{3, 5, 0,   7, 32'hFF000000, 7,  9,  32'h00808080, 1'b0, 32'h00808080};
        vecs[4]  = '{1, 5, 128, 0, 32'h00000000, 0,  0,  32'h11223344, 1'b1, 32'hFFFFFFFF};
        vecs[5]  = '{1, 5, 128, 0, 32'h00000000, 3,  15, 32'h11223344, 1'b0, 32'h00000000};
        vecs[6]  = '{2, 5, 128, 3, 32'h00FF0000, 12, 15, 32'hCAFEBABE, 1'b0, 32'hCAFEBABE};
        vecs[7]  = '{0, 0, 128, 3, 32'h00FF0000, 3,  15, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
        vecs[8]  = '{3, 6, 128, 7, 32'hFF000000, 7,  5,  32'h00808080, 1'b0, 32'h00808080};
        vecs[9]  = '{3, 0, 255, 2, 32'hFFFFFFFF, 2,  0,  32'h00000000, 1'b0, 32'hFEFEFEFE};
        vecs[10] = '{2, 0, 128, 9, 32'h12345678, 9,  0,  32'h01020304, 1'b0, 32'h12345678};
        vecs[11] = '{2, 0, 128, 9, 32'h12345678, 10, 15, 32'h01020304, 1'b0, 32'h01020304};

        areset = 1'b1;
        cfg_we = 1'b0; cfg_addr = 8'h0; cfg_wdata = '0;
        s_tuser = '0; s_tlast = 1'b0; s_tnumber = '0; s_tcount = '0;
        s_tdata = '0; s_tbinary = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
        model_reset();
        fork
            monitor();
        join_none
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;

        chk("reset_tvalid", {31'b0, m_tvalid}, 32'h0);
        chk("reset_tdata", m_tdata, 32'h0);
        chk("reset_user_last", {30'b0, m_tuser[0], m_tlast}, 32'h0);
        rd_chk("reset_mode", 8'h00, 32'h2);
        rd_chk("reset_th", 8'h01, 32'h5);
        rd_chk("reset_alpha", 8'h02, 32'd128);
        rd_chk("reset_upd", 8'h03, 32'h1);
        rd_chk("reset_pal0", 8'h10, 32'h0);
        rd_chk("unmapped_rd", 8'h55, 32'h0);

        for (int v = 0; v < 12; v++) begin
            cfg_write(8'h00, 32'(vecs[v].mode));
            cfg_write(8'h01, 32'(vecs[v].th));
            cfg_write(8'h02, 32'(vecs[v].alpha));
            cfg_write(8'(16 + vecs[v].pidx), vecs[v].pval);
            send_check($sformatf("vec%0d", v), 1'b1, 1'b1, vecs[v].num, vecs[v].cnt,
                       vecs[v].data, vecs[v].bin, vecs[v].exp);
        end
        rd_chk("pal9_rd", 8'h19, 32'h12345678);
        cfg_write(8'h55, 32'hFFFFFFFF);
        rd_chk("unmapped_after_wr", 8'h55, 32'h0);

        // Mid-frame palette change takes effect only from the next SOF beat.
        cfg_write(8'h00, 32'h2);
        cfg_write(8'h01, 32'h5);
        cfg_write(8'h13, 32'h00FF0000);
        send_check("mf_sof", 1'b1, 1'b0, 3, 5, 32'h11223344, 1'b0, 32'h00FF0000);
        cfg_write(8'h13, 32'h000000FF);
        send_check("mf_mid0", 1'b0, 1'b0, 3, 5, 32'h11223344, 1'b0, 32'h00FF0000);
        send_check("mf_mid1", 1'b0, 1'b1, 3, 5, 32'h11223344, 1'b0, 32'h00FF0000);
        send_check("mf_next_sof", 1'b1, 1'b0, 3, 5, 32'h11223344, 1'b0, 32'h000000FF);
        send_check("mf_next_mid", 1'b0, 1'b0, 3, 6, 32'h11223344, 1'b0, 32'h000000FF);
        send_check("wr_same_sof", 1'b1, 1'b0, 3, 5, 32'h11223344, 1'b0, 32'h000000FF,
                   1'b1, 8'h13, 32'hAAAAAAAA);
        send_check("wr_after_sof", 1'b1, 1'b0, 3, 5, 32'h11223344, 1'b0, 32'hAAAAAAAA);
        cfg_write(8'h03, 32'h0);
        cfg_write(8'h13, 32'h0000FF00);
        send_check("frozen_sof", 1'b1, 1'b0, 3, 5, 32'h11223344, 1'b0, 32'hAAAAAAAA);
        send_check("frozen_sof2", 1'b1, 1'b0, 3, 5, 32'h11223344, 1'b0, 32'hAAAAAAAA);
        rd_chk("frozen_shadow_rd", 8'h13, 32'h0000FF00);
        cfg_write(8'h03, 32'h1);
        send_check("unfrozen_sof", 1'b1, 1'b0, 3, 5, 32'h11223344, 1'b0, 32'h0000FF00);

        cfg_write(8'h00, 32'h3);
        cfg_write(8'h01, 32'h3);
        run_stream(64, -1);
        run_stream(64, -1);
        cfg_write(8'h00, 32'h1);
        run_stream(64, 20);
        send_check("post_reset_default", 1'b1, 1'b0, 3, 5, 32'h11223344, 1'b0, 32'h00000000);
        send_check("post_reset_nohit", 1'b1, 1'b0, 3, 4, 32'h11223344, 1'b0, 32'h11223344);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
